// File: rtl/warp_icache.sv
// warp_icache: direct-mapped read-only icache with even/odd doubleword banks serving unaligned 8-byte fetches.
// Define WARP_ICACHE_STATS_EN to add o_hit_count/o_miss_count.
module warp_icache #(
    parameter int SETS = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_imem_ren,
    input  logic [63:0] i_imem_raddr,
    output logic        o_imem_valid,
    output logic [63:0] o_imem_rdata,
    input  logic        i_flush,
    output logic        o_mem_req,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [63:0] i_mem_rdata
`ifdef WARP_ICACHE_STATS_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG_W = 60 - IDX;

    typedef enum logic [1:0] {IDLE, FILL_LO, FILL_HI, RESP} state_t;
    state_t state, nxt;

    logic [1:0][SETS-1:0] valid;
    logic [TAG_W-1:0] tag [2][SETS];
    logic [63:0] data [2][SETS];

    logic [63:0] addr_q, la, lo_rd, hi_rd, lo_buf, resp_lo, resp_hi, window;
    logic [60:0] dl, dh;
    logic [IDX-1:0] sl, shs, ws;
    logic [TAG_W-1:0] wt;
    logic lb, wb, need_hi, lo_hit, hi_hit, hit, fill, accept, install, drop_fill;
    logic unused;

    // During a fill the lookup runs on the latched address so the hi-miss decision sees live state.
    assign fill = state == FILL_LO || state == FILL_HI;
    assign la = fill ? addr_q : i_imem_raddr;
    assign unused = la[0];
    assign dl = la[63:3];
    assign dh = dl + 61'd1;
    assign need_hi = |la[2:1];
    assign lb = dl[0];
    assign sl = dl[IDX:1];
    assign shs = dh[IDX:1];
    assign lo_rd = data[lb][sl];
    assign hi_rd = data[~lb][shs];
    assign lo_hit = valid[lb][sl] && tag[lb][sl] == dl[60:IDX+1];
    assign hi_hit = valid[~lb][shs] && tag[~lb][shs] == dh[60:IDX+1];
    assign hit = lo_hit && (!need_hi || hi_hit);
    assign accept = i_imem_ren && (state == IDLE || state == RESP);

    assign wb = state == FILL_HI ? ~lb : lb;
    assign ws = state == FILL_HI ? shs : sl;
    assign wt = state == FILL_HI ? dh[60:IDX+1] : dl[60:IDX+1];
    assign install = fill && i_mem_ack && !drop_fill && !i_flush;

    // Refill data bypasses straight into the response window.
    assign resp_lo = state == FILL_HI ? lo_buf : state == FILL_LO ? i_mem_rdata : lo_rd;
    assign resp_hi = state == FILL_HI ? i_mem_rdata : hi_rd;
    assign window = 64'({resp_hi, resp_lo} >> {la[2:1], 4'b0});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, RESP: nxt = !accept ? IDLE : hit ? RESP : !lo_hit ? FILL_LO : FILL_HI;
            FILL_LO:    nxt = !i_mem_ack ? FILL_LO : (need_hi && !hi_hit) ? FILL_HI : RESP;
            FILL_HI:    nxt = i_mem_ack ? RESP : FILL_HI;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        o_imem_valid = state == RESP;
        o_mem_req = fill;
        o_mem_addr = state == FILL_LO ? {dl, 3'b0} : state == FILL_HI ? {dh, 3'b0} : 64'd0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            lo_buf <= '0;
            o_imem_rdata <= '0;
            drop_fill <= 1'b0;
            valid <= '0;
        end else begin
            if (accept) addr_q <= i_imem_raddr;
            if (accept) lo_buf <= lo_rd;
            else if (state == FILL_LO && i_mem_ack) lo_buf <= i_mem_rdata;
            if (nxt == RESP) o_imem_rdata <= window;
            drop_fill <= fill && (drop_fill || i_flush);
            if (i_flush) valid <= '0;
            else if (install) valid[wb][ws] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (install) begin
            tag[wb][ws] <= wt;
            data[wb][ws] <= i_mem_rdata;
        end
    end

`ifdef WARP_ICACHE_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hit_count <= '0;
            o_miss_count <= '0;
        end else if (accept) begin
            if (hit) o_hit_count <= o_hit_count + 32'd1;
            else o_miss_count <= o_miss_count + 32'd1;
        end
    end
`endif
endmodule
